// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle for mem_access_unit.
// A request transfers on a rising edge where req_valid & req_ready; rsp_valid is a one-cycle completion pulse.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front-end for a 1024x32 combinational-read memory; sub-word stores are read-modify-write.
// Optional macro ADDR_CHECK_EN: flag req_addr[31:12] != BASE_HI as an access error.
module mem_access_unit #(
  parameter logic [19:0] BASE_HI = 20'h00000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_access_unit_if.slave         bus,
  output logic [9:0]               dm_addr,
  output logic [31:0]              dm_din,
  output logic [3:0]               dm_be,
  output logic                     dm_wren,
  input  logic [31:0]              dm_dout,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  state_t      state;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [11:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;

  logic        range_err;
  logic        acc_err;
  logic        wr_access;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic [3:0]  lane_mask;

`ifdef ADDR_CHECK_EN
  logic [19:0] hi_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hi_q <= '0;
    else if (state == IDLE && bus.req_valid)
      hi_q <= bus.req_addr[31:12];
  end
  assign range_err = (hi_q != BASE_HI);
`else
  logic unused_hi;
  assign unused_hi = ^{BASE_HI, bus.req_addr[31:12]};
  assign range_err = 1'b0;
`endif

  assign acc_err = (size_q == 2'b11) ||
                   (size_q == 2'b01 && addr_q[0]) ||
                   (size_q == 2'b10 && addr_q[1:0] != 2'b00) ||
                   range_err;

  always_comb begin
    byte_v = dm_dout[7:0];
    case (addr_q[1:0])
      2'd1:    byte_v = dm_dout[15:8];
      2'd2:    byte_v = dm_dout[23:16];
      2'd3:    byte_v = dm_dout[31:24];
      default: byte_v = dm_dout[7:0];
    endcase
    half_v = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];
    case (size_q)
      2'b00:   load_val = {{24{byte_v[7] & ~uns_q}}, byte_v};
      2'b01:   load_val = {{16{half_v[15] & ~uns_q}}, half_v};
      default: load_val = dm_dout;
    endcase
  end

  // Merge store data into the word just read; lane_mask marks the lanes replaced.
  always_comb begin
    merged    = dm_dout;
    lane_mask = 4'b1111;
    if (size_q == 2'b00) begin
      lane_mask = 4'b0001 << addr_q[1:0];
      case (addr_q[1:0])
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        2'd3:    merged[31:24] = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (size_q == 2'b01) begin
      if (addr_q[1]) begin
        merged[31:16] = wdata_q[15:0];
        lane_mask     = 4'b1100;
      end else begin
        merged[15:0]  = wdata_q[15:0];
        lane_mask     = 4'b0011;
      end
    end
  end

  // Memory strobes are decoded from registered state only, so reset kills them at once.
  assign wr_access = (state == ACCESS) && we_q && (size_q == 2'b10) && !acc_err;
  assign dm_wren   = wr_access || (state == WRITE);
  assign dm_be     = wr_access ? 4'b1111 : ((state == WRITE) ? lane_mask : 4'b0000);
  assign dm_din    = wr_access ? wdata_q : ((state == WRITE) ? merge_q : 32'h0);
  assign dm_addr   = addr_q[11:2];
  assign bus.req_ready = (state == IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      uns_q         <= 1'b0;
      size_q        <= 2'b00;
      addr_q        <= '0;
      wdata_q       <= '0;
      merge_q       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            uns_q   <= bus.req_unsigned;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr[11:0];
            wdata_q <= bus.req_wdata;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (acc_err) begin
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else if (!we_q) begin
            bus.rsp_rdata <= load_val;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else if (size_q == 2'b10) begin
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else begin
            merge_q <= merged;
            state   <= WRITE;
          end
        end
        WRITE: begin
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        default: begin
          bus.rsp_valid <= 1'b0;
          bus.rsp_err   <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: behavioural memory, driver tasks, queue scoreboard with a response monitor.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic [3:0]  dm_be;
  logic        dm_wren;
  logic [31:0] dm_dout;
  logic [1:0]  dbg_state;
  logic        preload;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dm_addr   (dm_addr),
    .dm_din    (dm_din),
    .dm_be     (dm_be),
    .dm_wren   (dm_wren),
    .dm_dout   (dm_dout),
    .dbg_state (dbg_state)
  );

  // clock / reset / memory
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  assign dm_dout = mem[dm_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[5] <= 32'h8899AABB;
    end else if (dm_wren) begin
      mem[dm_addr] <= dm_din;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: {rdata[31:0], err, latency[7:0]}
  logic [40:0] exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_exp_rsp = 0;
  int          n_rsp = 0;
  int          acc_cyc = 0;
  logic [31:0] last_load = 32'h0;

  int          wr_cnt = 0;
  logic [31:0] wr_din;
  logic [3:0]  wr_be;
  int          wr_rel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // response monitor
  always @(negedge clk) begin
    logic [40:0] e;
    if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
    if (bus.rsp_valid) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 want no response");
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e[40:9]);
        chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e[8]});
        chk("rsp_latency", cyc - acc_cyc, {24'h0, e[7:0]});
        chk("ready_in_resp", {31'h0, bus.req_ready}, 32'h0);
      end
    end
  end

  // write monitor; strobes must be quiet when no write is in progress
  always @(negedge clk) begin
    if (dm_wren) begin
      wr_cnt++;
      wr_din = dm_din;
      wr_be  = dm_be;
      wr_rel = cyc - acc_cyc;
    end else if (dm_be != 4'h0 || dm_din != 32'h0) begin
      n_vec++;
      n_bad++;
      $display("FAIL idle_strobes: got be=%h din=%h want 0", dm_be, dm_din);
    end
  end

  // driver: call at posedge+#1; returns at posedge+#1 after the accept edge
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input logic keep, input logic expect_rsp);
    logic [31:0] rd;
    logic [7:0]  lat;
    logic        got;
    int          n;
    if (expect_rsp) begin
      if (!we && !exp_err) begin
        rd        = exp_rdata;
        last_load = exp_rdata;
      end else begin
        rd = last_load;
      end
      lat = (we && size != 2'b10 && !exp_err) ? 8'd3 : 8'd2;
      exp_q.push_back({rd, exp_err, lat});
      n_exp_rsp++;
    end
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    n = 0;
    do begin
      @(negedge clk);
      got = bus.req_ready;
      n++;
    end while (!got && n < 100);
    if (!got) chk("accept_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    chk("ready_low_after_accept", {31'h0, bus.req_ready}, 32'h0);
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic ld(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                    input logic [31:0] exp_rdata, input logic exp_err);
    send(1'b0, size, uns, addr, 32'h0, exp_rdata, exp_err, 1'b0, 1'b1);
  endtask

  task automatic st(input logic [1:0] size, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic exp_err);
    send(1'b1, size, 1'b0, addr, wdata, 32'h0, exp_err, 1'b0, 1'b1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("response_timeout", exp_q.size(), 32'h0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    preload          = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_dm_wren", {31'h0, dm_wren}, 32'h0);
    chk("rst_dm_be", {28'h0, dm_be}, 32'h0);
    chk("rst_dm_din", dm_din, 32'h0);
    chk("rst_dm_addr", {22'h0, dm_addr}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    preload = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);

    // sub-word loads from word 5 = 8899AABB
    ld(2'b00, 1'b0, 32'h15, 32'hFFFFFFAA, 1'b0);
    ld(2'b00, 1'b1, 32'h17, 32'h00000088, 1'b0);
    ld(2'b01, 1'b1, 32'h16, 32'h00008899, 1'b0);
    ld(2'b01, 1'b0, 32'h14, 32'hFFFFAABB, 1'b0);
    ld(2'b00, 1'b0, 32'h14, 32'hFFFFFFBB, 1'b0);
    ld(2'b00, 1'b1, 32'h16, 32'h00000099, 1'b0);
    ld(2'b01, 1'b0, 32'h16, 32'hFFFF8899, 1'b0);
    wait_done();

    // byte store via read-modify-write
    wr_cnt = 0;
    st(2'b00, 32'h15, 32'h00000011, 1'b0);
    wait_done();
    chk("sb_wr_count", wr_cnt, 32'd1);
    chk("sb_wr_din", wr_din, 32'h889911BB);
    chk("sb_wr_be", {28'h0, wr_be}, 32'h2);
    chk("sb_wr_cycle", wr_rel, 32'd2);
    ld(2'b10, 1'b0, 32'h14, 32'h889911BB, 1'b0);
    wait_done();

    // word store writes in ACCESS
    wr_cnt = 0;
    st(2'b10, 32'h20, 32'hDEADBEEF, 1'b0);
    wait_done();
    chk("sw_wr_count", wr_cnt, 32'd1);
    chk("sw_wr_din", wr_din, 32'hDEADBEEF);
    chk("sw_wr_be", {28'h0, wr_be}, 32'hF);
    chk("sw_wr_cycle", wr_rel, 32'd1);
    chk("sw_mem", mem[8], 32'hDEADBEEF);

    // error cases never write
    wr_cnt = 0;
    st(2'b01, 32'h21, 32'h00005555, 1'b1);
    ld(2'b10, 1'b0, 32'h23, 32'h0, 1'b1);
    ld(2'b11, 1'b0, 32'h20, 32'h0, 1'b1);
    st(2'b10, 32'h22, 32'h12345678, 1'b1);
    wait_done();
    chk("err_wr_count", wr_cnt, 32'd0);
    chk("err_mem", mem[8], 32'hDEADBEEF);
    ld(2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0);

    // half and upper-byte stores
    st(2'b01, 32'h22, 32'hFFFF1234, 1'b0);
    st(2'b00, 32'h23, 32'h000000A5, 1'b0);
    ld(2'b01, 1'b1, 32'h22, 32'h0000A534, 1'b0);
    st(2'b01, 32'h20, 32'h00007E01, 1'b0);
    wait_done();
    chk("sh_mem", mem[8], 32'hA5347E01);

    // back-to-back with req_valid held high
    send(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h00000001, 1'b0, 1'b1, 1'b1);
    send(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b1, 1'b1);
    send(1'b1, 2'b00, 1'b0, 32'h24, 32'h000000C3, 32'h0, 1'b0, 1'b1, 1'b1);
    send(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h889911BB, 1'b0, 1'b1, 1'b1);
    send(1'b0, 2'b00, 1'b1, 32'h24, 32'h0, 32'h000000C3, 1'b0, 1'b0, 1'b1);
    wait_done();

    // reset during the WRITE cycle of a byte store
    wr_cnt = 0;
    send(1'b1, 2'b00, 1'b0, 32'h15, 32'h00000077, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("wren_in_write", {31'h0, dm_wren}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_kills_wren", {31'h0, dm_wren}, 32'h0);
    chk("rst_kills_be", {28'h0, dm_be}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    last_load = 32'h0;
    chk("rst_mid_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_mid_wr_count", wr_cnt, 32'd0);
    chk("rst_mid_mem", mem[5], 32'h889911BB);
    @(posedge clk);
    #1;
    ld(2'b10, 1'b0, 32'h14, 32'h889911BB, 1'b0);
    wait_done();

`ifdef ADDR_CHECK_EN
    wr_cnt = 0;
    ld(2'b10, 1'b0, 32'h00001000, 32'h0, 1'b1);
    st(2'b10, 32'h00001014, 32'h0BADF00D, 1'b1);
    wait_done();
    chk("range_wr_count", wr_cnt, 32'd0);
    chk("range_mem", mem[5], 32'h889911BB);
`endif

    repeat (3) @(posedge clk);
    chk("response_count", n_rsp, n_exp_rsp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
